// File: rtl/uart_pwm_pkg.sv
// uart_pwm_pkg: shared states and protocol bytes for the UART PWM LED controller
package uart_pwm_pkg;
    typedef enum logic [1:0] {IDLE, GET_CH, GET_DUTY, EXEC} parser_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
endpackage

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: synchronised 8N1 receiver with mid-bit sampling, start glitch rejection and stop check
module uart_rx_8n1
    import uart_pwm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       pll_clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    rx_state_t state, state_n;
    logic [2:0] sync;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] sh_n;
    logic valid_n, err_n;
    always_ff @(posedge pll_clk or negedge rst_n)
        if (!rst_n) begin
            sync      <= '1;
            state     <= RX_IDLE;
            cnt       <= '0;
            idx       <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[1:0], rx};
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            rx_data   <= sh_n;
            rx_valid  <= valid_n;
            frame_err <= err_n;
        end
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        sh_n    = rx_data;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n   = '0;
                state_n = (sync[2] && !sync[1]) ? RX_START : RX_IDLE;
            end
            RX_START: if (cnt == HALF_END) begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = sync[1] ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt == BIT_END) begin
                cnt_n   = '0;
                idx_n   = idx + 1'b1;
                sh_n    = {sync[1], rx_data[7:1]};
                state_n = &idx ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (cnt == BIT_END) begin
                state_n = RX_IDLE;
                valid_n = sync[1];
                err_n   = !sync[1];
            end
            default: state_n = RX_IDLE;
        endcase
    end
endmodule

// File: rtl/uart_pwm_led_ctrl.sv
// uart_pwm_led_ctrl: UART command parser driving period-aligned PWM LED channels with ACK/NAK replies
module uart_pwm_led_ctrl
    import uart_pwm_pkg::*;
#(
    parameter int N_CH = 11,
    parameter int PWM_BITS = 8,
    parameter int CLKS_PER_BIT = 217,
    parameter int TIMEOUT_CLKS = 65536,
    parameter logic [N_CH-1:0] ACTIVE_LOW_MASK = N_CH'(3'b111)
) (
    input  logic            pll_clk,
    input  logic            rst_n,
    input  logic            uart_rx_i,
    output logic            uart_tx_o,
    output logic [N_CH-1:0] led_o,
    output logic            frame_err_o,
    output logic [15:0]     cmd_count_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0] N_CH_B = 8'(N_CH);
    logic [7:0] rx_data;
    logic rx_valid;
    parser_state_t ps, ps_n;
    logic [7:0] ch_q, ch_n;
    logic [PWM_BITS-1:0] duty_q, duty_n, cnt;
    logic [TW-1:0] tmo;
    logic exec, hit;
    logic [N_CH-1:0] raw;
    logic [7:0] resp, go_b, pend_b;
    logic pend_v, tx_busy, tx_free, go;
    logic [8:0] tx_sh;
    logic [3:0] tx_left;
    logic [CW-1:0] tx_cnt;

    uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .pll_clk   (pll_clk),
        .rst_n     (rst_n),
        .rx        (uart_rx_i),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err_o)
    );

    always_ff @(posedge pll_clk or negedge rst_n)
        if (!rst_n) begin
            ps          <= IDLE;
            ch_q        <= '0;
            duty_q      <= '0;
            tmo         <= '0;
            cnt         <= '0;
            cmd_count_o <= '0;
            led_o       <= ACTIVE_LOW_MASK;
        end else begin
            ps          <= ps_n;
            ch_q        <= ch_n;
            duty_q      <= duty_n;
            tmo         <= (rx_valid || ps == IDLE || ps == EXEC) ? '0 : tmo + 1'b1;
            cnt         <= cnt + 1'b1;
            cmd_count_o <= hit ? cmd_count_o + 1'b1 : cmd_count_o;
            led_o       <= raw ^ ACTIVE_LOW_MASK;
        end
    always_comb begin
        ps_n   = ps;
        ch_n   = ch_q;
        duty_n = duty_q;
        case (ps)
            IDLE:     ps_n = (rx_valid && rx_data == SYNC_BYTE) ? GET_CH : IDLE;
            GET_CH: begin
                ch_n = rx_valid ? rx_data : ch_q;
                ps_n = rx_valid ? GET_DUTY : (tmo == TMO_END ? IDLE : GET_CH);
            end
            GET_DUTY: begin
                duty_n = rx_valid ? PWM_BITS'(rx_data) : duty_q;
                ps_n   = rx_valid ? EXEC : (tmo == TMO_END ? IDLE : GET_DUTY);
            end
            default:  ps_n = IDLE;
        endcase
        if (frame_err_o) ps_n = IDLE;
    end
    assign exec = ps == EXEC;
    assign hit  = exec && ch_q < N_CH_B;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [PWM_BITS-1:0] shadow, duty;
        logic wr;
        assign wr     = hit && ch_q == 8'(i);
        assign raw[i] = cnt < duty;
        always_ff @(posedge pll_clk or negedge rst_n)
            if (!rst_n) begin
                shadow <= '0;
                duty   <= '0;
            end else begin
                if (wr) shadow <= duty_q;
                if (&cnt) duty <= wr ? duty_q : shadow;
            end
    end

    assign resp    = hit ? ACK_BYTE : NAK_BYTE;
    assign tx_free = !tx_busy || (tx_cnt == BIT_END && tx_left == '0);
    assign go      = tx_free && (exec || pend_v);
    assign go_b    = exec ? resp : pend_b;
    always_ff @(posedge pll_clk or negedge rst_n)
        if (!rst_n) begin
            uart_tx_o <= 1'b1;
            tx_busy   <= 1'b0;
            tx_sh     <= '1;
            tx_left   <= '0;
            tx_cnt    <= '0;
            pend_v    <= 1'b0;
            pend_b    <= '0;
        end else begin
            if (exec && !tx_free) begin
                pend_v <= 1'b1;
                pend_b <= resp;
            end else if (go) pend_v <= 1'b0;
            if (go) begin
                uart_tx_o <= 1'b0;
                tx_sh     <= {1'b1, go_b};
                tx_left   <= 4'd9;
                tx_cnt    <= '0;
                tx_busy   <= 1'b1;
            end else if (tx_busy) begin
                tx_cnt <= tx_cnt == BIT_END ? '0 : tx_cnt + 1'b1;
                if (tx_cnt == BIT_END && tx_left == '0) tx_busy <= 1'b0;
                else if (tx_cnt == BIT_END) begin
                    uart_tx_o <= tx_sh[0];
                    tx_sh     <= {1'b1, tx_sh[8:1]};
                    tx_left   <= tx_left - 1'b1;
                end
            end
        end
endmodule

// File: doc/uart_pwm_led_ctrl.md
Name: uart_pwm_led_ctrl

Overview:
- Parametrised board-I/O controller for the pico-ice class of designs.
- Receives 3-byte UART commands that set the duty of any of N_CH PWM LED channels: RGB LED plus PMOD LEDs.
- Acknowledges each command over UART TX.
- Sits between the PLL clock domain and the board pins, replacing direct pin driving with glitch-free, period-aligned PWM.

Parameters:
- N_CH, 11, number of PWM channels (3 RGB + 8 PMOD); 1..127
- PWM_BITS, 8, PWM counter and duty width; period = 2^PWM_BITS clocks
- CLKS_PER_BIT, 217, pll_clk cycles per UART bit (25 MHz / 115200); min 4
- TIMEOUT_CLKS, 65536, inter-byte timeout returning the parser to IDLE
- ACTIVE_LOW_MASK, 11'b111, per-channel output inversion (RGB pins are active-low)

Ports:
- pll_clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- uart_rx_i  in  1  asynchronous serial input, 8N1
- uart_tx_o  out  1  serial ACK/NAK output, 8N1, idle high
- led_o  out  N_CH  PWM outputs; bit i is XORed with ACTIVE_LOW_MASK[i]
- frame_err_o  out  1  one-cycle pulse on a bad stop bit
- cmd_count_o  out  16  count of accepted commands, wraps at 0xFFFF

Behaviour:
- Reset values:
  - all duty and shadow registers 0
  - led_o = ACTIVE_LOW_MASK (all LEDs dark)
  - uart_tx_o = 1, frame_err_o = 0, cmd_count_o = 0
  - parser in IDLE, PWM counter 0
- Reset asserted mid-frame or mid-TX aborts immediately; no partial state survives.
- RX path:
  - 2-flop synchroniser on uart_rx_i.
  - Start detected on a synchronised falling edge; start re-checked at half bit.
  - If start is high at half bit, it is a glitch: return to idle with no byte and no error.
  - Data sampled LSB first at bit centres.
  - Stop bit = 0 → frame_err_o pulses one cycle, byte discarded, parser forced to IDLE.
  - rx_valid is a one-cycle strobe, asserted 1 cycle after the stop-bit centre sample.
- Parser FSM:
  - IDLE: byte 0xA5 → GET_CH; any other byte is ignored.
  - GET_CH: latch ch → GET_DUTY.
  - GET_DUTY: latch duty[PWM_BITS-1:0] (upper byte bits ignored if PWM_BITS < 8; PWM_BITS > 8 zero-extends) → EXEC.
  - EXEC, 1 cycle:
    - If ch < N_CH: write shadow[ch], increment cmd_count_o, queue ACK 0x06.
    - Otherwise: no write, queue NAK 0x15.
    - Then → IDLE.
  - Timeout: in GET_CH/GET_DUTY, an idle counter reaching TIMEOUT_CLKS-1 with no rx_valid → IDLE. Counter clears on every rx_valid.
- PWM:
  - Free-running counter cnt of PWM_BITS, wraps naturally.
  - raw[i] = (cnt < duty[i]); duty 0 = always off; duty max = on for (2^PWM_BITS - 1) of every 2^PWM_BITS clocks.
  - led_o registered: 1-cycle latency from cnt.
  - Shadow-to-duty copy happens only on the cycle cnt == all-ones, so new duty takes effect at the start of the next period, with no glitch.
  - A write landing on the all-ones cycle itself is copied in that same cycle.
- TX path:
  - One-entry response queue.
  - If TX is idle, the byte starts on the next cycle.
  - If TX is busy, the byte is held pending.
  - A further response while pending overwrites the pending byte; this cannot occur at legal line rates and is not an error.
  - Frame = start, 8 data bits LSB first, stop; each bit CLKS_PER_BIT cycles.
- RX and TX operate full-duplex and independently.

Decomposition:
- Shared package uart_pwm_pkg:
  - parser state enum (IDLE, GET_CH, GET_DUTY, EXEC)
  - constants SYNC_BYTE=8'hA5, ACK_BYTE=8'h06, NAK_BYTE=8'h15
- Sub-module uart_rx_8n1: synchroniser, bit timing, rx_data/rx_valid/frame_err outputs.
- TX, parser and PWM stay in the top block.

Test Plan:
Use CLKS_PER_BIT=4, PWM_BITS=4, TIMEOUT_CLKS=64 for all scenarios.
- Send A5 00 08 → within 1 period led_o[0] (active-low) is low for 8 of 16 clocks. TX returns 0x06. cmd_count_o=1.
- Send A5 0B 05 with N_CH=11 → TX returns 0x15; no led_o change; cmd_count_o unchanged.
- Send A5 03, wait 70 clocks, then 0x0F → no write. Parser is in IDLE when 0x0F arrives and ignores it. No TX byte.
- Byte with stop bit = 0 inside a frame → frame_err_o single pulse. Next A5 05 0F is accepted: led_o[5] high 15 of 16 clocks.
- Write duty 4 → 12 mid-period on ch 4 → current period still shows 4 high clocks, next period shows 12, no runt pulse.
- Assert rst_n low mid-TX of an ACK → uart_tx_o=1 and led_o=ACTIVE_LOW_MASK immediately. After release, TX stays idle.
